trap_ctrl: RTL

- Sequences all trap-related updates of the machine-mode CSR file and arbitrates its single write port.
- Takes synchronous exceptions from the commit point, gated machine interrupts, mret, and ordinary W-stage CSR writes.
- Serialises the trap-entry writes to mepc, mcause, mtval and mstatus, then redirects fetch to mtvec.
- Sits between the W stage, the CSR file (write port, is_mret) and pcselect.

---
 rtl/csr_pkg.sv | 10 +
 rtl/trap_pkg.sv | 36 +++
 rtl/trap_ctrl_if.sv | 47 ++++
 rtl/trap_ctrl_chk.sv | 14 +
 rtl/trap_ctrl_irq_arbiter.sv | 29 ++
 rtl/trap_ctrl.sv | 199 +++++++++++++++++++
 6 files changed

// File: rtl/csr_pkg.sv
// Machine-mode CSR addresses shared by the CSR file and its trap sequencer.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

endpackage

// File: rtl/trap_pkg.sv
// Shared types and constants for the trap controller.
package trap_pkg;

    // Number of serialised CSR writes performed on trap entry (mepc, mcause, mtval, mstatus).
    localparam int TRAP_WRITES = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        W_EPC     = 3'd1,
        W_CAUSE   = 3'd2,
        W_TVAL    = 3'd3,
        W_STATUS  = 3'd4,
        JUMP      = 3'd5,
        MRET      = 3'd6,
        MRET_JUMP = 3'd7
    } trap_state_e;

    // Interrupt cause codes (low bits of mcause).
    localparam logic [3:0] IRQ_MEI = 4'd11;
    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_MTI = 4'd7;

    // mstatus bit positions.
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // CSR addresses come from the CSR file package so both sides agree.
    localparam logic [11:0] CSR_MSTATUS = csr_pkg::CSR_MSTATUS;
    localparam logic [11:0] CSR_MTVEC   = csr_pkg::CSR_MTVEC;
    localparam logic [11:0] CSR_MEPC    = csr_pkg::CSR_MEPC;
    localparam logic [11:0] CSR_MCAUSE  = csr_pkg::CSR_MCAUSE;
    localparam logic [11:0] CSR_MTVAL   = csr_pkg::CSR_MTVAL;

endpackage

// File: rtl/trap_ctrl_if.sv
// Bundle of commit-point, CSR-file and fetch-redirect signals around the trap controller.
interface trap_ctrl_if #(parameter int XLEN = 64);

    logic            exc_valid;
    logic [XLEN-1:0] exc_pc;
    logic [XLEN-1:0] exc_cause;
    logic [XLEN-1:0] exc_tval;
    logic [2:0]      irq_pend;
    logic [2:0]      mie_en;
    logic [XLEN-1:0] mstatus;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic            commit_valid;
    logic [XLEN-1:0] commit_pc;
    logic            mret_valid;
    logic            wb_csr_valid;
    logic [11:0]     wb_csr_wa;
    logic [XLEN-1:0] wb_csr_wd;
    logic            csr_valid;
    logic [11:0]     csr_wa;
    logic [XLEN-1:0] csr_wd;
    logic            csr_is_mret;
    logic            stall;
    logic            flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            busy;

    // Pipeline / CSR file side.
    modport master (
        output exc_valid, exc_pc, exc_cause, exc_tval, irq_pend, mie_en,
               mstatus, mtvec, mepc, commit_valid, commit_pc, mret_valid,
               wb_csr_valid, wb_csr_wa, wb_csr_wd,
        input  csr_valid, csr_wa, csr_wd, csr_is_mret, stall, flush,
               redirect_valid, redirect_pc, busy
    );

    // Trap controller side.
    modport slave (
        input  exc_valid, exc_pc, exc_cause, exc_tval, irq_pend, mie_en,
               mstatus, mtvec, mepc, commit_valid, commit_pc, mret_valid,
               wb_csr_valid, wb_csr_wa, wb_csr_wd,
        output csr_valid, csr_wa, csr_wd, csr_is_mret, stall, flush,
               redirect_valid, redirect_pc, busy
    );

endinterface

// File: rtl/trap_ctrl_chk.sv
// Protocol checks for the trap controller.
module trap_ctrl_chk (
    input logic clk,
    input logic reset,
    input logic busy,
    input logic exc_valid,
    input logic wb_csr_valid
);

    // The pipeline is stalled while a sequence runs, so no new exception or W-stage write may appear
    a_quiet_while_busy: assert property (@(posedge clk) disable iff (!reset)
        busy |-> !(exc_valid || wb_csr_valid));

endmodule

// File: rtl/trap_ctrl_irq_arbiter.sv
// Priority encoder for machine interrupts: external > software > timer.
module irq_arbiter
    import trap_pkg::*;
(
    input  logic [2:0] irq_pend,   // {MEIP, MTIP, MSIP}
    input  logic [2:0] mie_en,     // {MEIE, MTIE, MSIE}
    input  logic       mie,        // mstatus.MIE
    output logic       take,
    output logic [3:0] code
);

    logic [2:0] live_s;

    // Pick the highest-priority interrupt that is both pending and enabled
    always_comb begin
        live_s = irq_pend & mie_en;
        take   = mie & (|live_s);
        if (live_s[2]) begin
            code = IRQ_MEI;
        end else if (live_s[0]) begin
            code = IRQ_MSI;
        end else if (live_s[1]) begin
            code = IRQ_MTI;
        end else begin
            code = 4'd0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: serialises trap-entry CSR writes, handles mret, and owns the CSR write port.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN = 64
) (
    input logic       clk,
    input logic       reset,
    trap_ctrl_if.slave bus
);

    trap_state_e     state_r, state_nxt_s;
    logic [XLEN-1:0] epc_r, cause_r, tval_r;
    logic            irq_raw_s, irq_take_s, accept_s;
    logic [3:0]      irq_code_s;
    logic [XLEN-1:0] irq_cause_s, trap_base_s, trap_target_s;

    logic            csr_valid_s, csr_is_mret_s, stall_s, flush_s, redirect_valid_s, busy_s;
    logic [11:0]     csr_wa_s;
    logic [XLEN-1:0] csr_wd_s, redirect_pc_s;

    // mstatus image written on trap entry: stash MIE in MPIE, disable, record M-mode in MPP.
    function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r                                = ms;
        r[MSTATUS_MPIE]                  = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]                   = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    irq_arbiter u_irq_arbiter (
        .irq_pend (bus.irq_pend),
        .mie_en   (bus.mie_en),
        .mie      (bus.mstatus[MSTATUS_MIE]),
        .take     (irq_raw_s),
        .code     (irq_code_s)
    );

    trap_ctrl_chk u_chk (
        .clk          (clk),
        .reset        (reset),
        .busy         (busy_s),
        .exc_valid    (bus.exc_valid),
        .wb_csr_valid (bus.wb_csr_valid)
    );

    assign irq_take_s  = irq_raw_s & bus.commit_valid;
    assign accept_s    = bus.exc_valid | irq_take_s | bus.mret_valid;
    assign irq_cause_s = {1'b1, {(XLEN-5){1'b0}}, irq_code_s};

    // Trap vector: vectored mode offsets by 4*cause, but only for interrupts
    always_comb begin
        trap_base_s = {bus.mtvec[XLEN-1:2], 2'b00};
        if ((bus.mtvec[1:0] == 2'b01) && cause_r[XLEN-1]) begin
            trap_target_s = trap_base_s + {{(XLEN-8){1'b0}}, cause_r[5:0], 2'b00};
        end else begin
            trap_target_s = trap_base_s;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture epc/cause/tval (or mepc for mret) in the accept cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epc_r   <= {XLEN{1'b0}};
            cause_r <= {XLEN{1'b0}};
            tval_r  <= {XLEN{1'b0}};
        end else if (state_r == IDLE) begin
            if (bus.exc_valid) begin
                epc_r   <= bus.exc_pc;
                cause_r <= bus.exc_cause;
                tval_r  <= bus.exc_tval;
            end else if (irq_take_s) begin
                epc_r   <= bus.commit_pc;
                cause_r <= irq_cause_s;
                tval_r  <= {XLEN{1'b0}};
            end else if (bus.mret_valid) begin
                epc_r   <= bus.mepc;
            end
        end
    end

    // Next-state: exception > interrupt > mret from IDLE, fixed walk otherwise
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE: begin
                if (bus.exc_valid || irq_take_s) begin
                    state_nxt_s = W_EPC;
                end else if (bus.mret_valid) begin
                    state_nxt_s = MRET;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            W_EPC:     state_nxt_s = W_CAUSE;
            W_CAUSE:   state_nxt_s = W_TVAL;
            W_TVAL:    state_nxt_s = W_STATUS;
            W_STATUS:  state_nxt_s = JUMP;
            JUMP:      state_nxt_s = IDLE;
            MRET:      state_nxt_s = MRET_JUMP;
            MRET_JUMP: state_nxt_s = IDLE;
            default:   state_nxt_s = IDLE;
        endcase
    end

    // Drive CSR port, pipeline control and redirect; everything is held at zero during reset
    always_comb begin
        csr_valid_s      = 1'b0;
        csr_wa_s         = 12'h000;
        csr_wd_s         = {XLEN{1'b0}};
        csr_is_mret_s    = 1'b0;
        stall_s          = 1'b0;
        flush_s          = 1'b0;
        redirect_valid_s = 1'b0;
        redirect_pc_s    = {XLEN{1'b0}};
        busy_s           = 1'b0;
        if (!reset) begin
            busy_s = 1'b0;
        end else begin
            busy_s = (state_r != IDLE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        // The trapping / returning instruction must not commit its CSR write.
                        stall_s = 1'b1;
                    end else begin
                        csr_valid_s = bus.wb_csr_valid;
                        csr_wa_s    = bus.wb_csr_wa;
                        csr_wd_s    = bus.wb_csr_wd;
                    end
                end
                W_EPC: begin
                    csr_valid_s = 1'b1;
                    csr_wa_s    = CSR_MEPC;
                    csr_wd_s    = {epc_r[XLEN-1:2], 2'b00};
                    flush_s     = 1'b1;
                    stall_s     = 1'b1;
                end
                W_CAUSE: begin
                    csr_valid_s = 1'b1;
                    csr_wa_s    = CSR_MCAUSE;
                    csr_wd_s    = cause_r;
                    stall_s     = 1'b1;
                end
                W_TVAL: begin
                    csr_valid_s = 1'b1;
                    csr_wa_s    = CSR_MTVAL;
                    csr_wd_s    = tval_r;
                    stall_s     = 1'b1;
                end
                W_STATUS: begin
                    csr_valid_s = 1'b1;
                    csr_wa_s    = CSR_MSTATUS;
                    csr_wd_s    = mstatus_on_trap(bus.mstatus);
                    stall_s     = 1'b1;
                end
                JUMP: begin
                    redirect_valid_s = 1'b1;
                    redirect_pc_s    = trap_target_s;
                    stall_s          = 1'b1;
                end
                MRET: begin
                    csr_is_mret_s = 1'b1;
                    flush_s       = 1'b1;
                    stall_s       = 1'b1;
                end
                MRET_JUMP: begin
                    redirect_valid_s = 1'b1;
                    redirect_pc_s    = epc_r;
                    stall_s          = 1'b1;
                end
                default: begin
                    stall_s = 1'b0;
                end
            endcase
        end
    end

    assign bus.csr_valid      = csr_valid_s;
    assign bus.csr_wa         = csr_wa_s;
    assign bus.csr_wd         = csr_wd_s;
    assign bus.csr_is_mret    = csr_is_mret_s;
    assign bus.stall          = stall_s;
    assign bus.flush          = flush_s;
    assign bus.redirect_valid = redirect_valid_s;
    assign bus.redirect_pc    = redirect_pc_s;
    assign bus.busy           = busy_s;

endmodule
